adc128s022_scan: RTL and testbench



---
 rtl/adc128s022_scan.sv | 175 +++++++++++++++++
 tb/tb_adc128s022_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc128s022_scan.sv
// adc128s022_scan -- continuous channel scanner for the ADC128S022 serial ADC.
//
// Runs back-to-back 16-SCLK frames while enable is high. Each frame sends
// the next channel address from CH_MASK and reads back the conversion of the
// channel addressed in the previous frame. The result is tagged with that
// previous address. The first frame after reset or after IDLE is a dummy.
//
// Ports:
//   clock_50     in   system clock, rising edge
//   reset        in   synchronous, active-high
//   enable       in   level; frames run back to back while high
//   adc_cs_n     out  ADC chip select, active low
//   adc_sclk     out  ADC serial clock, idles high
//   adc_saddr    out  ADC DIN (control word, MSB first)
//   adc_sdat     in   ADC DOUT
//   sample_valid out  one-cycle pulse per new result
//   sample_ch    out  channel of the current result
//   sample_data  out  12-bit unsigned result
module adc128s022_scan #(
  parameter int          CLK_HALF = 8,
  parameter logic [7:0]  CH_MASK  = 8'hFF
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_saddr,
  input  logic        adc_sdat,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data
);

  localparam int            CW       = $clog2(CLK_HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLK_HALF / 2);

  // Next set mask bit above a, wrapping; returns a if it is the only one.
  function automatic logic [2:0] next_ch(input logic [2:0] a);
    logic [2:0] r;
    logic [2:0] c;
    logic       found;
    r     = a;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      c = a + 3'(i);
      if (!found && CH_MASK[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Searching upward from 7 lands on the lowest set bit.
  localparam logic [2:0] FIRST_CH = next_ch(3'd7);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          phase_q;    // 0: SCLK low half, 1: SCLK high half
  logic [3:0]    bit_q;
  logic [15:0]   ctrl_q;
  logic [11:0]   sh_q;       // only the last 12 received bits are ever used
  logic [2:0]    addr_q, prev_q, ptr_q;
  logic          discard_q;
  logic          saddr_q;
  logic          cnt_last;

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign adc_saddr = saddr_q;

  always_ff @(posedge clock_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable && (CH_MASK != 8'h00)) state_d = CS_SETUP;
      CS_SETUP: if (cnt_last) state_d = SHIFT;
      SHIFT:    if (cnt_last && phase_q && (bit_q == 4'd15)) state_d = CS_HOLD;
      CS_HOLD:  if (cnt_last) state_d = enable ? CS_SETUP : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    adc_cs_n = 1'b1;
    adc_sclk = 1'b1;
    case (state_q)
      CS_SETUP: adc_cs_n = 1'b0;
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = phase_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      bit_q        <= '0;
      ctrl_q       <= '0;
      sh_q         <= '0;
      addr_q       <= '0;
      prev_q       <= '0;
      ptr_q        <= FIRST_CH;
      discard_q    <= 1'b1;
      saddr_q      <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
    end else begin
      sample_valid <= 1'b0;
      cnt_q        <= (state_q == IDLE || cnt_last) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (state_d == CS_SETUP) begin
            addr_q <= ptr_q;
            ctrl_q <= {2'b00, ptr_q, 11'b0};
          end
        end
        CS_SETUP: begin
          if (cnt_last) begin
            phase_q <= 1'b0;
            bit_q   <= '0;
            saddr_q <= ctrl_q[15];
          end
        end
        SHIFT: begin
          if (phase_q && cnt_q == CNT_MID) sh_q <= {sh_q[10:0], adc_sdat};
          if (cnt_last) begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else if (bit_q == 4'd15) begin
              // Last high cycle: the word is complete, so the result is
              // published in the first CS_HOLD cycle.
              saddr_q <= 1'b0;
              if (!discard_q) begin
                sample_valid <= 1'b1;
                sample_data  <= sh_q;
                sample_ch    <= prev_q;
              end
              discard_q <= 1'b0;
              prev_q    <= addr_q;
              ptr_q     <= next_ch(addr_q);
            end else begin
              bit_q   <= bit_q + 4'd1;
              phase_q <= 1'b0;
              saddr_q <= ctrl_q[4'(4'd14 - bit_q)];
            end
          end
        end
        CS_HOLD: begin
          if (cnt_last) begin
            if (enable) begin
              addr_q <= ptr_q;
              ctrl_q <= {2'b00, ptr_q, 11'b0};
            end else begin
              discard_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc128s022_scan.sv
// Bench for adc128s022_scan: three instances (full mask, sparse mask, empty
// mask) share one clock, each with a small ADC model that returns 12'hA5C.
module tb_adc128s022_scan;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst [3];
  logic        en  [3];
  logic        cs_n[3], sclk[3], saddr[3], vld[3];
  logic        sdat[3] = '{1'b0, 1'b0, 1'b0};
  logic [2:0]  sch  [3];
  logic [11:0] sdata[3];

  adc128s022_scan u_a (
    .clock_50(clk), .reset(rst[0]), .enable(en[0]), .adc_cs_n(cs_n[0]),
    .adc_sclk(sclk[0]), .adc_saddr(saddr[0]), .adc_sdat(sdat[0]),
    .sample_valid(vld[0]), .sample_ch(sch[0]), .sample_data(sdata[0]));

  adc128s022_scan #(.CH_MASK(8'b1010_0100)) u_b (
    .clock_50(clk), .reset(rst[1]), .enable(en[1]), .adc_cs_n(cs_n[1]),
    .adc_sclk(sclk[1]), .adc_saddr(saddr[1]), .adc_sdat(sdat[1]),
    .sample_valid(vld[1]), .sample_ch(sch[1]), .sample_data(sdata[1]));

  adc128s022_scan #(.CH_MASK(8'h00)) u_c (
    .clock_50(clk), .reset(rst[2]), .enable(en[2]), .adc_cs_n(cs_n[2]),
    .adc_sclk(sclk[2]), .adc_saddr(saddr[2]), .adc_sdat(sdat[2]),
    .sample_valid(vld[2]), .sample_ch(sch[2]), .sample_data(sdata[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor + ADC model (samples on falling clk edge)
  logic [15:0] word = 16'h0A5C;
  int frames[3] = '{0, 0, 0};
  int fc[3], rc[3], setup[3], tail[3];
  int last_setup[3], last_tail[3], last_gap[3], rise_cyc[3];
  int fall_err[3] = '{0, 0, 0};
  int saddr_err[3] = '{0, 0, 0};
  int width_err[3] = '{0, 0, 0};
  int p_n[3] = '{0, 0, 0};
  int p_cyc[3][64], p_ch[3][64], p_data[3][64], p_frame[3][64];
  int fall_cyc[3][64], addr_rec[3][64];
  logic [2:0] addr_w[3];
  logic prev_cs[3]    = '{1'b1, 1'b1, 1'b1};
  logic prev_sclk[3]  = '{1'b1, 1'b1, 1'b1};
  logic prev_saddr[3] = '{1'b0, 1'b0, 1'b0};
  logic prev_vld[3]   = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!cs_n[d] && prev_cs[d]) begin
        if (frames[d] > 0) last_gap[d] = cyc - rise_cyc[d];
        if (frames[d] < 64) fall_cyc[d][frames[d]] = cyc;
        frames[d]++;
        fc[d] = 0; rc[d] = 0; setup[d] = 0; tail[d] = 0; addr_w[d] = '0;
      end
      if (!cs_n[d]) begin
        if (prev_sclk[d] && !sclk[d]) begin
          if (fc[d] < 16) sdat[d] = word[15 - fc[d]];
          fc[d]++;
        end
        if (!prev_sclk[d] && sclk[d]) begin
          rc[d]++;
          if (rc[d] >= 3 && rc[d] <= 5) addr_w[d] = {addr_w[d][1:0], saddr[d]};
          if (rc[d] == 5 && frames[d] <= 64) addr_rec[d][frames[d]-1] = int'(addr_w[d]);
        end
        if (sclk[d] && saddr[d] != prev_saddr[d]) saddr_err[d]++;
        if (sclk[d] && fc[d] == 0)  setup[d]++;
        if (sclk[d] && fc[d] == 16) tail[d]++;
      end
      if (cs_n[d] && !prev_cs[d]) begin
        if (fc[d] != 16 && !rst[d]) fall_err[d]++;
        last_setup[d] = setup[d];
        last_tail[d]  = tail[d];
        rise_cyc[d]   = cyc;
      end
      if (vld[d]) begin
        if (p_n[d] < 64) begin
          p_cyc[d][p_n[d]]   = cyc;
          p_ch[d][p_n[d]]    = int'(sch[d]);
          p_data[d][p_n[d]]  = int'(sdata[d]);
          p_frame[d][p_n[d]] = frames[d];
        end
        p_n[d]++;
        if (prev_vld[d]) width_err[d]++;
      end
      prev_cs[d]    = cs_n[d];
      prev_sclk[d]  = sclk[d];
      prev_saddr[d] = saddr[d];
      prev_vld[d]   = vld[d];
    end
  end

  // ---------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int sel;   // 0: A pulse ch, 1: A pulse data, 2: B pulse ch, 3: B saddr per frame
    int idx;
    int exp;
  } vec_t;

  vec_t  tbl[26];
  string sel_name[4] = '{"a_ch", "a_data", "b_ch", "b_saddr"};
  int    b_seq[4]    = '{2, 5, 7, 2};
  int    act, pb, fb;

  initial begin
    for (int k = 0; k < 9; k++) begin
      tbl[k]     = '{sel: 0, idx: k, exp: k % 8};
      tbl[9 + k] = '{sel: 1, idx: k, exp: 'hA5C};
    end
    for (int k = 0; k < 4; k++) begin
      tbl[18 + k] = '{sel: 2, idx: k, exp: b_seq[k]};
      tbl[22 + k] = '{sel: 3, idx: k, exp: b_seq[k]};
    end

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      en[d]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  int'(cs_n[0]),  1);
    chk("rst_sclk",  int'(sclk[0]),  1);
    chk("rst_saddr", int'(saddr[0]), 0);
    chk("rst_valid", int'(vld[0]),   0);
    chk("rst_ch",    int'(sch[0]),   0);
    chk("rst_data",  int'(sdata[0]), 0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Continuous scan from reset release.
    for (int i = 0; i < 4000 && p_n[0] < 9; i++) @(posedge clk);
    #1;
    chk("a_nine_pulses", int'(p_n[0] >= 9), 1);
    for (int i = 0; i < 26; i++) begin
      case (tbl[i].sel)
        0:       act = p_ch[0][tbl[i].idx];
        1:       act = p_data[0][tbl[i].idx];
        2:       act = p_ch[1][tbl[i].idx];
        default: act = addr_rec[1][tbl[i].idx];
      endcase
      chk($sformatf("%s[%0d]", sel_name[tbl[i].sel], tbl[i].idx), act, tbl[i].exp);
    end
    chk("a_first_pulse_frame", p_frame[0][0], 2);
    chk("a_first_latency", p_cyc[0][0] - fall_cyc[0][0], 536);
    for (int k = 1; k < 9; k++)
      chk($sformatf("a_gap[%0d]", k), p_cyc[0][k] - p_cyc[0][k-1], 272);
    chk("a_cs_setup_len", last_setup[0], 8);
    chk("a_last_high_len", last_tail[0], 8);
    chk("a_cs_hold_len", last_gap[0], 8);
    chk("a_16_falls", fall_err[0], 0);
    chk("b_16_falls", fall_err[1], 0);
    chk("saddr_stable", saddr_err[0] + saddr_err[1], 0);
    chk("pulse_width", width_err[0] + width_err[1], 0);

    // Reset during SHIFT bit 9.
    for (int i = 0; i < 400 && !(fc[0] == 10 && !cs_n[0]); i++) @(posedge clk);
    #1;
    chk("reach_bit9", int'(fc[0] == 10 && !cs_n[0]), 1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("rst9_cs_n",  int'(cs_n[0]),  1);
    chk("rst9_sclk",  int'(sclk[0]),  1);
    chk("rst9_valid", int'(vld[0]),   0);
    chk("rst9_data",  int'(sdata[0]), 0);
    pb = p_n[0];
    fb = frames[0];
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 1000 && p_n[0] <= pb; i++) @(posedge clk);
    #1;
    chk("restart_pulse", int'(p_n[0] > pb), 1);
    chk("restart_ch", p_ch[0][pb], 0);
    chk("restart_frame", p_frame[0][pb] - fb, 2);
    chk("restart_data", p_data[0][pb], 'hA5C);

    // Drop enable in the middle of frame 5.
    for (int i = 0; i < 2000 && !(frames[0] - fb == 5 && fc[0] == 8); i++) @(posedge clk);
    #1;
    chk("reach_frame5", int'(frames[0] - fb == 5 && fc[0] == 8), 1);
    en[0] = 1'b0;
    en[2] = 1'b0;
    for (int i = 0; i < 600 && p_n[0] - pb < 4; i++) @(posedge clk);
    #1;
    chk("frame5_pulse", p_n[0] - pb, 4);
    chk("frame5_ch", p_ch[0][pb + 3], 3);
    chk("frame5_frame", p_frame[0][pb + 3] - fb, 5);
    repeat (700) @(posedge clk);
    #1;
    chk("idle_frames", frames[0] - fb, 5);
    chk("idle_pulses", p_n[0] - pb, 4);
    chk("idle_cs_n", int'(cs_n[0]), 1);
    en[0] = 1'b1;
    en[2] = 1'b1;
    for (int i = 0; i < 1000 && p_n[0] - pb < 5; i++) @(posedge clk);
    #1;
    chk("reenable_pulse", p_n[0] - pb, 5);
    chk("reenable_frame", p_frame[0][pb + 4] - fb, 7);
    chk("reenable_ch", p_ch[0][pb + 4], 5);
    repeat (300) @(posedge clk);
    #1;

    // Empty mask never starts a frame.
    chk("c_frames", frames[2], 0);
    chk("c_pulses", p_n[2], 0);
    chk("c_cs_n", int'(cs_n[2]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
